uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter that shares a single `uart_tx` transmitter between `NREQ` byte requesters.
- Picks one pending requester and hands its byte to the transmitter with a one-cycle start pulse.
- Acknowledges the requester, then holds the transmitter until the serial frame completes.
- Sits between the peripheral's byte producers (message generators, echo paths, debug taps) and the `uart_tx`/`baudgen` pair.
- Lets several sources print on one TX line without corrupting frames.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in NREQ: requester i has a byte pending; held until `ack[i]`.
- `data_in` in NREQ*8: byte of requester i on bits [8i+7:8i]; stable while `req[i]` is high.
- `ack` out NREQ: one-cycle pulse; byte of requester i captured.
- `grant` out NREQ: one-hot owner of the transmitter; all zero when free.
- `tx_start` out 1: one-cycle start pulse to `uart_tx`.
- `tx_data` out 8: byte to `uart_tx`, registered.
- `tx_ready` in 1: `uart_tx` idle, high between frames.
- `busy` out 1: high in every state except IDLE.

## Operation
State machine:
- IDLE
  - Exits only when `tx_ready`=1 and at least one requester is eligible.
  - On exit, registers the winner into `grant`, latches its byte into `tx_data`, and goes to START.
- START
  - `tx_start`=1 and `ack[winner]`=1, both for exactly this cycle.
  - Goes to WAIT_BUSY.
- WAIT_BUSY
  - Waits for `tx_ready`=0.
  - Goes to WAIT_READY.
- WAIT_READY
  - Waits for `tx_ready`=1.
  - Updates `last` = winner index, then goes to IDLE.

Arbitration rules:
- Round-robin priority starts at (`last`+1) mod NREQ and scans upward with wrap.
- `last` resets to NREQ-1, so requester 0 wins first after reset.
- `grant` clears on the IDLE entry following the frame, unless the lock feature holds it.

Boundary conditions:
- Single requester with `req` held continuously: served back-to-back, one byte per frame.
- Requester keeps `req` high after `ack`: this presents its next byte. It is sampled at the next IDLE exit.
- `req[i]` drops after being latched, before `ack`: the byte is still sent and `ack` still pulses.
- `req` rising while busy: queued by level; no loss.
- Simultaneous requests: only one winner per frame. Losers keep `req` high and are served in round-robin order.
- `tx_ready`=0 in IDLE, e.g. a frame started elsewhere or uart not yet out of reset: no grant is issued.

## Timing
- Reset value of every output is 0, including `tx_data`. Reset is effective immediately, mid-frame included; state returns to IDLE and `last` to NREQ-1.
- Latency: `req` high in IDLE at cycle k with `tx_ready`=1 gives `tx_start`/`ack` at k+1.
- Frame occupancy: 2 cycles of arbiter overhead plus the `uart_tx` frame, 10 bit times = `BAUDRATE`*10 clocks.
- Minimum gap between successive `tx_start` pulses equals the frame time plus 2 cycles.
- `ack` and `tx_start` are always coincident. `grant` is stable from START through WAIT_READY.

## Configuration
- `UART_ARB_LOCK_EN` defined:
  - Adds input `lock` [NREQ], which keeps a message contiguous.
  - At WAIT_READY exit, if `lock[winner]`=1, `grant` and ownership are retained.
  - In IDLE, only the owner is eligible, even if its `req` is low. The arbiter waits in IDLE, still granted, until the owner raises `req` or drops `lock`.
  - Dropping `lock` releases ownership at the next IDLE cycle; rotation resumes from `last`.
- `UART_ARB_LOCK_EN` undefined: port `lock` is absent, and rotation happens after every byte.

## Structure
- Shared package `uart_arb_pkg` holds:
  - state encoding (IDLE, START, WAIT_BUSY, WAIT_READY);
  - default NREQ;
  - byte width 8.
- Baud constants come from the existing `baudgen.vh`.
- One natural sub-module: `rr_pick`, a combinational round-robin picker (`req` vector, `last` index → one-hot winner plus valid).

## Test plan
Bench: NREQ=4, `uart_tx` at `B115200`, `tx` decoded by a serial monitor.
- Reset released, `req`=4'b0001, byte 0x41 → `tx_start`+`ack[0]` one cycle later; line carries 0x41; `grant` returns to 0.
- `req`=4'b1111 with bytes 0x30..0x33 held until each `ack` → line order 0x30,0x31,0x32,0x33; exactly one `ack` per requester.
- Requester 2 keeps `req` high with 0x55 while requester 1 requests 0xAA → line alternates 0x55,0xAA,0x55 (after `last`=1).
- Assert `rst` mid-frame during WAIT_BUSY → all outputs 0 immediately; after release, requester 0 has priority.
- `UART_ARB_LOCK_EN`: requester 3 sends "HI" (0x48, 0x49) with `lock[3]`=1 while requester 0 requests 0x2A → line 0x48,0x49,0x2A.
- Hold `tx_ready`=0 externally with `req`=4'b0100 → no `tx_start`/`ack`; releasing `tx_ready` gives a grant within 1 cycle.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default requester count, byte width and a one-hot to index helper.
package uart_arb_pkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int BYTE_W       = 8;
    localparam int MAX_NREQ     = 8;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_START      = 2'd1,
        ST_WAIT_BUSY  = 2'd2,
        ST_WAIT_READY = 2'd3
    } arb_state_t;

    // Index of the set bit of a one-hot vector (up to MAX_NREQ wide).
    // Returns 0 for an all-zero vector.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_NREQ-1:0] oh);
        logic [2:0] idx_v;
        idx_v = 3'd0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (oh[i]) begin
                idx_v = idx_v | 3'(i);
            end else begin
                idx_v = idx_v;
            end
        end
        return idx_v;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: starting one above the last winner and
// wrapping around, returns the first requesting line as a one-hot vector.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEFAULT,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  winner,
    output logic             valid
);

    logic [NREQ-1:0] winner_s;
    logic            found_s;

    // Scan from last+1 upward with wrap; first requester found wins.
    always_comb begin
        int idx_v;
        winner_s = '0;
        found_s  = 1'b0;
        idx_v    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_v = (int'(last) + k) % NREQ;
            if (!found_s && req[idx_v]) begin
                winner_s[idx_v] = 1'b1;
                found_s         = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign winner = winner_s;
    assign valid  = found_s;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NREQ byte requesters.
// A winner is granted, its byte latched into tx_data and a single
// tx_start/ack pulse issued; the grant is then held until the frame ends
// (tx_ready low, then high again).
// Optional feature: define UART_ARB_LOCK_EN to add the `lock` input, which
// lets the current owner keep the transmitter across several bytes.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*BYTE_W-1:0] data_in,
`ifdef UART_ARB_LOCK_EN
    input  logic [NREQ-1:0]        lock,
`endif
    output logic [NREQ-1:0]        ack,
    output logic [NREQ-1:0]        grant,
    output logic                   tx_start,
    output logic [BYTE_W-1:0]      tx_data,
    input  logic                   tx_ready,
    output logic                   busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t        state_r;
    arb_state_t        state_s;

    logic [NREQ-1:0]   ack_r;
    logic [NREQ-1:0]   grant_r;
    logic              tx_start_r;
    logic [BYTE_W-1:0] tx_data_r;
    logic              busy_r;
    logic [IDX_W-1:0]  last_r;
    logic              owner_r;

    logic [NREQ-1:0]   ack_s;
    logic [NREQ-1:0]   grant_s;
    logic              tx_start_s;
    logic [BYTE_W-1:0] tx_data_s;
    logic              busy_s;
    logic [IDX_W-1:0]  last_s;
    logic              owner_s;

    logic [NREQ-1:0]   lock_s;
    logic              owner_held_s;
    logic              frame_lock_s;
    logic [NREQ-1:0]   eligible_s;
    logic [NREQ-1:0]   pick_oh_s;
    logic              pick_valid_s;
    logic [BYTE_W-1:0] pick_byte_s;
    logic [IDX_W-1:0]  grant_idx_s;

`ifdef UART_ARB_LOCK_EN
    assign lock_s = lock;
`else
    // Without the lock feature ownership never persists past one byte.
    assign lock_s = '0;
`endif

    // The current owner keeps exclusive eligibility while it holds lock.
    assign owner_held_s = owner_r && (|(lock_s & grant_r));
    // Lock of the requester whose frame is in flight.
    assign frame_lock_s = |(lock_s & grant_r);
    assign eligible_s   = owner_held_s ? (req & grant_r) : req;
    assign grant_idx_s  = IDX_W'(onehot_to_idx(MAX_NREQ'(grant_r)));

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (eligible_s),
        .last   (last_r),
        .winner (pick_oh_s),
        .valid  (pick_valid_s)
    );

    // Byte of the picked requester, selected by its one-hot winner bit.
    always_comb begin
        pick_byte_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh_s[i]) begin
                pick_byte_s = pick_byte_s | data_in[i*BYTE_W +: BYTE_W];
            end else begin
                pick_byte_s = pick_byte_s;
            end
        end
    end

    // FSM state register; reset drops straight back to IDLE, even mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state: grant only when the transmitter is idle, then follow
    // the uart through its busy/ready handshake.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tx_ready && pick_valid_s) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_s = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!tx_ready) begin
                    state_s = ST_WAIT_READY;
                end else begin
                    state_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_READY: begin
                if (tx_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_READY;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: next values of every registered output, so that start,
    // ack and grant appear together in the cycle the FSM enters START.
    always_comb begin
        ack_s      = '0;
        tx_start_s = 1'b0;
        grant_s    = grant_r;
        tx_data_s  = tx_data_r;
        last_s     = last_r;
        owner_s    = owner_r;
        busy_s     = (state_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (tx_ready && pick_valid_s) begin
                    grant_s    = pick_oh_s;
                    tx_data_s  = pick_byte_s;
                    ack_s      = pick_oh_s;
                    tx_start_s = 1'b1;
                    owner_s    = 1'b0;
                end else if (!owner_held_s) begin
                    // Free, or lock just dropped: release the transmitter.
                    grant_s = '0;
                    owner_s = 1'b0;
                end else begin
                    // Locked owner without a byte yet: keep waiting, granted.
                    grant_s = grant_r;
                    owner_s = 1'b1;
                end
            end
            ST_START: begin
                grant_s = grant_r;
            end
            ST_WAIT_BUSY: begin
                grant_s = grant_r;
            end
            ST_WAIT_READY: begin
                if (tx_ready) begin
                    last_s = grant_idx_s;
                    if (frame_lock_s) begin
                        grant_s = grant_r;
                        owner_s = 1'b1;
                    end else begin
                        grant_s = '0;
                        owner_s = 1'b0;
                    end
                end else begin
                    grant_s = grant_r;
                end
            end
            default: begin
                grant_s = '0;
                owner_s = 1'b0;
            end
        endcase
    end

    // Output and rotation registers; everything clears on reset and the
    // rotation pointer restarts so requester 0 has first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_r      <= '0;
            grant_r    <= '0;
            tx_start_r <= 1'b0;
            tx_data_r  <= '0;
            busy_r     <= 1'b0;
            last_r     <= IDX_W'(NREQ - 1);
            owner_r    <= 1'b0;
        end else begin
            ack_r      <= ack_s;
            grant_r    <= grant_s;
            tx_start_r <= tx_start_s;
            tx_data_r  <= tx_data_s;
            busy_r     <= busy_s;
            last_r     <= last_s;
            owner_r    <= owner_s;
        end
    end

    assign ack      = ack_r;
    assign grant    = grant_r;
    assign tx_start = tx_start_r;
    assign tx_data  = tx_data_r;
    assign busy     = busy_r;

endmodule
